// File: rtl/fd_pkg.sv
// Shared field layout and constants for the fetch/decode pipeline register.
// Optional stall counter is enabled with the FD_STALL_CNT_EN macro (see fd_decode_reg).
package fd_pkg;
    localparam int REG_W     = 5;
    localparam int IMM_W     = 17;
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 27;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int RS_MSB    = 21;
    localparam int RS_LSB    = 17;
    localparam int RT_MSB    = 16;
    localparam int RT_LSB    = 12;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/fd_skid_fifo.sv
// Two-entry in-order storage with occupancy count; flush empties it in one cycle.
module fd_skid_fifo
    import fd_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush wins over any same-cycle push or pop.
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
endmodule

// File: rtl/fd_decode_reg.sv
// Fetch/decode pipeline register: 2-entry buffer plus head field slicing.
// Define FD_STALL_CNT_EN to build the stall-cycle counter; otherwise stall_count is tied to 0.
module fd_decode_reg
    import fd_pkg::*;
#(
    parameter int INSN_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [INSN_W-1:0] in_insn,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [INSN_W-1:0] out_insn,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_W-1:0]  out_op,
    output logic [REG_W-1:0]  out_aluop,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [31:0]       out_imm,
    output logic [31:0]       stall_count
);
    localparam int DW = INSN_W + PC_W;

    logic [DW-1:0]     head_data;
    logic [1:0]        count;
    logic              push, pop;
    logic [INSN_W-1:0] head_insn;
    logic [PC_W-1:0]   head_pc;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    fd_skid_fifo #(.W(DW)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .wr_data   ({in_insn, in_pc}),
        .head_data (head_data),
        .count     (count)
    );

    // Stale storage is masked so every field reads zero whenever the buffer is empty.
    assign head_insn = out_valid ? head_data[DW-1:PC_W] : INSN_W'(NOP_INSN);
    assign head_pc   = out_valid ? head_data[PC_W-1:0]  : '0;

    assign out_insn  = head_insn;
    assign out_pc    = head_pc;
    assign out_op    = head_insn[OP_MSB:OP_LSB];
    assign out_aluop = head_insn[ALUOP_MSB:ALUOP_LSB];
    assign out_rd    = head_insn[RD_MSB:RD_LSB];
    assign out_rs    = head_insn[RS_MSB:RS_LSB];
    assign out_rt    = head_insn[RT_MSB:RT_LSB];
    assign out_imm   = sext_imm(head_insn[IMM_W-1:0]);

`ifdef FD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_fd_decode_reg.sv
// Randomized and directed bench for fd_decode_reg against a queue-based reference model.
module tb_fd_decode_reg;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic [4:0]  out_op, out_aluop, out_rd, out_rs, out_rt;
    logic [31:0] out_imm;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] model_q[$];
    logic [31:0] stall_exp = 0;

    fd_decode_reg #(.INSN_W(32), .PC_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_insn    (out_insn),
        .out_pc      (out_pc),
        .out_op      (out_op),
        .out_aluop   (out_aluop),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_imm     (out_imm),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ctx);
        logic [31:0] hi, hp, imm;
        hi = 0;
        hp = 0;
        if (model_q.size() > 0) begin
            hi = model_q[0][63:32];
            hp = model_q[0][31:0];
        end
        imm = hi & 32'h1FFFF;
        if (imm >= 32'h10000) imm = imm + 32'hFFFE_0000;
        check_eq({ctx, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
        check_eq({ctx, ".in_ready"},  64'(in_ready),  64'(model_q.size() < 2));
        check_eq({ctx, ".out_insn"},  64'(out_insn),  64'(hi));
        check_eq({ctx, ".out_pc"},    64'(out_pc),    64'(hp));
        check_eq({ctx, ".out_op"},    64'(out_op),    64'((hi >> 27) % 32));
        check_eq({ctx, ".out_aluop"}, 64'(out_aluop), 64'((hi >> 2) % 32));
        check_eq({ctx, ".out_rd"},    64'(out_rd),    64'((hi >> 22) % 32));
        check_eq({ctx, ".out_rs"},    64'(out_rs),    64'((hi >> 17) % 32));
        check_eq({ctx, ".out_rt"},    64'(out_rt),    64'((hi >> 12) % 32));
        check_eq({ctx, ".out_imm"},   64'(out_imm),   64'(imm));
        check_eq({ctx, ".stall"},     64'(stall_count), 64'(stall_exp));
    endtask

    // One clock of stimulus: drive, update the model at the edge, check at the next falling edge.
    task automatic step(input string ctx, input bit v, input logic [31:0] insn,
                        input logic [31:0] pc, input bit fl, input bit ordy);
        int pre;
        in_valid  = v;
        in_insn   = insn;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        @(posedge clock);
        pre = model_q.size();
`ifdef FD_STALL_CNT_EN
        if (pre > 0 && !ordy && !fl) stall_exp = stall_exp + 1;
`endif
        if (fl) begin
            model_q.delete();
        end else begin
            if (pre > 0 && ordy) void'(model_q.pop_front());
            if (v && pre < 2) model_q.push_back({insn, pc});
        end
        @(negedge clock);
        $display("step %s v=%0d insn=%08h fl=%0d rdy=%0d -> valid=%0d head=%08h", ctx, v, insn, fl, ordy,
                 out_valid, out_insn);
        check_outputs(ctx);
    endtask

    task automatic async_reset(input string ctx);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        stall_exp = 0;
        check_outputs(ctx);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_insn   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs("reset");
        reset_n = 1'b1;

        // Zero instruction passes straight through with one cycle latency.
        step("nop_in",  1, 32'h0000_0000, 32'h100, 0, 1);
        step("nop_out", 0, 32'h0, 32'h0, 0, 1);

        // Fill to two with downstream stalled; head must hold.
        step("fill0", 1, 32'h2884_0001, 32'h200, 0, 0);
        step("fill1", 1, 32'h0000_0014, 32'h204, 0, 0);
        for (int i = 0; i < 6; i++) step("hold", 1, $urandom, $urandom, 0, 0);
        check_eq("hold.op",  64'(out_op),  64'd5);
        check_eq("hold.imm", 64'(out_imm), 64'd1);

        // Flush while full with a live input: input dropped.
        step("flush", 1, 32'hDEAD_BEEF, 32'h300, 1, 0);
        check_eq("flush.valid", 64'(out_valid), 64'd0);

        // Streaming at occupancy one.
        step("prime", 1, 32'h1111_0000, 32'h400, 0, 0);
        for (int i = 0; i < 10; i++) step("stream", 1, 32'h2000_0000 + 32'(i), 32'h404 + 32'(4*i), 0, 1);

        // Negative immediate sign extension.
        step("imm_neg", 1, 32'h0001_FFFF, 32'h500, 0, 1);
        check_eq("imm_neg.imm", 64'(out_imm), 64'hFFFF_FFFF);

        // Asynchronous reset while full.
        step("pre_rst0", 1, 32'hABCD_1234, 32'h600, 0, 0);
        step("pre_rst1", 1, 32'h5555_AAAA, 32'h604, 0, 0);
        async_reset("mid_reset");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 7) == 0) ins = ins | 32'h0001_FFFF;
            step("rand", $urandom_range(0, 3) != 0, ins, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fd_decode_reg.md
FD_DECODE_REG -- requirements
Module: fd_decode_reg

Interface
REQ-001 Parameter INSN_W, default 32: instruction width in bits.
REQ-002 Parameter PC_W, default 32: program-counter width in bits.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port in_valid, input, 1: fetch offers an instruction.
REQ-006 Port in_insn, input, INSN_W: fetched instruction.
REQ-007 Port in_pc, input, PC_W: PC of the fetched instruction.
REQ-008 Port in_ready, output, 1: block can accept this cycle.
REQ-009 Port flush, input, 1: branch/jump squash of all held instructions.
REQ-010 Port out_ready, input, 1: decode/ALU-control stage consumes head.
REQ-011 Port out_valid, output, 1: head entry valid.
REQ-012 Port out_insn, output, INSN_W, and port out_pc, output, PC_W: head instruction and its PC.
REQ-013 Port out_op, output, 5: head insn[31:27], feeds the opcode decoder.
REQ-014 Port out_aluop, output, 5: head insn[6:2], feeds the ALU-op decoder.
REQ-015 Port out_rd/out_rs/out_rt, output, 5 each: head insn[26:22]/[21:17]/[16:12].
REQ-016 Port out_imm, output, 32: head insn[16:0] sign-extended from bit 16.
REQ-017 Port stall_count, output, 32: stall cycle counter (see Configuration).

Function
REQ-018 The block SHALL be an in-order 2-entry buffer with occupancy count 0..2.
REQ-019 Accept: in_valid && in_ready; dispatch: out_valid && out_ready.
REQ-020 in_ready SHALL be combinational !(count==2), independent of out_ready.
REQ-021 out_valid SHALL equal (count!=0); all out_* fields SHALL derive only from the registered head entry.
REQ-022 Latency: an instruction accepted into an empty buffer SHALL appear on out_* the next cycle.
REQ-023 Simultaneous accept and dispatch SHALL leave count unchanged and preserve order.
REQ-024 At count 2 with out_ready low, the head and its out_* values SHALL hold stable.
REQ-025 Flush SHALL have priority: the next cycle count=0, out_valid=0, and any same-cycle input is discarded.
REQ-026 Dispatch during a flush cycle still counts as consumed by downstream; the block treats it as dropped.
REQ-027 Field extraction SHALL be unconditional on opcode; when out_valid=0, fields SHALL read zero.

Reset
REQ-028 While reset_n=0: count=0, out_valid=0, in_ready=1, all data/field outputs=0, stall_count=0.
REQ-029 Reset asserted mid-transfer SHALL drop all held entries; there is no replay.

Configuration
REQ-030 Macro FD_STALL_CNT_EN defined: stall_count SHALL increment (wrapping at 2^32) every cycle with out_valid && !out_ready && !flush.
REQ-031 Macro FD_STALL_CNT_EN undefined: stall_count SHALL be constant 0 and no counter register exists.

Structure
REQ-032 Package fd_pkg SHALL hold the field bit positions, REG_W=5, IMM_W=17, and NOP_INSN=0.
REQ-033 Sub-module fd_skid_fifo SHALL hold the 2-entry storage and count; field slicing stays in the top.

Verification
REQ-034 Reset, then in_insn=0x00000000 valid for 1 cycle, out_ready=1 -> the next cycle out_valid=1, out_op=0, out_aluop=0; the following cycle out_valid=0.
REQ-035 Hold out_ready=0 and push 0x2884_0001 and then 0x0000_0014 -> count 2, in_ready=0, head stays 0x2884_0001 (out_op=5, out_imm=1).
REQ-036 With count 1, perform simultaneous accept and dispatch for 10 cycles -> one instruction out per cycle, in order, count stays 1.
REQ-037 Apply flush with count 2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, input not stored.
REQ-038 Use in_insn bits[16:0]=0x1FFFF -> out_imm=0xFFFFFFFF; with FD_STALL_CNT_EN, 7 stalled cycles -> stall_count=7; with the macro undefined, stall_count stays 0.
REQ-039 Drop reset_n mid-stream with count 2 -> outputs reach reset values immediately, without waiting for a clock edge.
